// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared parameters and types for the FIFO write-port arbiter.
//   DATA_WIDTH  : default write word width
//   word_t      : one write word
//   arb_state_t : arbiter FSM state encoding
package fifo_param_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BLOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer-side and memory-side signals around the write arbiter.
//   master : environment side (producers + memory) - drives req, wdata,
//            mem_full, mem_wr_err; observes grants and status
//   slave  : arbiter side - drives gnt, mem_wr_en, mem_wdata, fifo_full,
//            err_cnt, busy
interface fifo_wr_arbiter_if
    import fifo_param_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = fifo_param_pkg::DATA_WIDTH,
    parameter int ERR_CNT_W  = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic                          mem_full;
    logic                          mem_wr_err;
    logic                          mem_wr_en;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic                          fifo_full;
    logic [ERR_CNT_W-1:0]          err_cnt;
    logic                          busy;

    modport master (
        output req, wdata, mem_full, mem_wr_err,
        input  gnt, mem_wr_en, mem_wdata, fifo_full, err_cnt, busy
    );

    modport slave (
        input  req, wdata, mem_full, mem_wr_err,
        output gnt, mem_wr_en, mem_wdata, fifo_full, err_cnt, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   eligible : requesters that may be granted this cycle
//   rr_ptr   : index with highest priority; scan wraps modulo NUM_REQ
//   winner   : one-hot winner (all zero when nothing eligible)
//   win_idx  : binary index of the winner
//   valid    : a winner exists
module rr_pick
    import fifo_param_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   win_idx,
    output logic               valid
);

    // One extra bit so rr_ptr + offset cannot overflow before the modulo fold.
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        valid   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!valid && eligible[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of the FIFO memory's single write port.
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   bus.req/wdata   : per-producer request and packed data words
//   bus.gnt         : one-hot, one-cycle grant (word accepted)
//   bus.mem_full    : memory cannot take a write next cycle (stalls all)
//   bus.mem_wr_err  : memory flags current write as erroneous
//   bus.mem_wr_en/mem_wdata : registered write port to memory
//   bus.fifo_full   : registered copy of mem_full for producers
//   bus.err_cnt     : saturating count of mem_wr_err cycles
//   bus.busy        : FSM in GRANT or BLOCKED
module fifo_wr_arbiter
    import fifo_param_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = fifo_param_pkg::DATA_WIDTH,
    parameter int ERR_CNT_W  = 8
) (
    input logic              CLK,
    input logic              nRST,
    fifo_wr_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [PTR_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    win_onehot;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] win_data;

    // A requester granted last cycle still has req high; mask it for a cycle.
    assign eligible = bus.req & ~bus.gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (win_onehot),
        .win_idx  (win_idx),
        .valid    (win_valid)
    );

    // AND-OR mux of the winning slice; winner is one-hot or zero.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_data = win_data | bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

    // Every state shares the same exit rule: full stalls, otherwise grant
    // whenever someone is eligible. Entering GRANT is what issues a grant.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, GRANT, BLOCKED: begin
                if (bus.mem_full) begin
                    state_nxt = BLOCKED;
                end else if (win_valid) begin
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.gnt       <= '0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_wdata <= '0;
            bus.fifo_full <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.fifo_full <= bus.mem_full;
            bus.busy      <= (state_nxt != IDLE);
            if (state_nxt == GRANT) begin
                bus.gnt       <= win_onehot;
                bus.mem_wr_en <= 1'b1;
                bus.mem_wdata <= win_data;
                rr_ptr        <= ptr_nxt;
            end else begin
                bus.gnt       <= '0;
                bus.mem_wr_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.err_cnt <= '0;
        end else if (bus.mem_wr_err && (bus.err_cnt != '1)) begin
            bus.err_cnt <= bus.err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter in front of the FIFO memory's single write port. Up to NUM_REQ producers each present a request and a data word. The arbiter grants one producer per cycle, registers the winning word onto the memory write port, and stalls all producers while the memory reports full. It also mirrors the full flag back to producers and counts write errors reported by the memory.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, write data width
- ERR_CNT_W, 8, width of the saturating error counter
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester write request; held high with data stable until granted
- wdata  input  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  output  NUM_REQ  one-hot grant, one-cycle pulse; the word was accepted
- mem_full  input  1  memory cannot accept a write on the next cycle
- mem_wr_err  input  1  memory flags the current write as erroneous
- mem_wr_en  output  1  write strobe to memory
- mem_wdata  output  DATA_WIDTH  write data to memory
- fifo_full  output  1  registered copy of mem_full, for producers
- err_cnt  output  ERR_CNT_W  saturating count of mem_wr_err cycles
- busy  output  1  high when the FSM is in GRANT or BLOCKED

## Operation
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low (nRST).
- Reset values: gnt=0, mem_wr_en=0, mem_wdata=0, fifo_full=0, err_cnt=0, busy=0, rr_ptr=0, state=IDLE.
- Eligibility:
  - eligible[i] = req[i] & ~gnt[i].
  - A requester granted last cycle is masked for one cycle, so its still-high req is not re-granted.
- Selection: the winner is the first eligible index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- On a grant to k:
  - gnt[k] is set to 1 and mem_wr_en to 1.
  - mem_wdata receives wdata slice k.
  - rr_ptr becomes (k+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
- When no grant is made: gnt=0 and mem_wr_en=0. mem_wdata holds its last value. rr_ptr is unchanged.
- FSM states: IDLE, GRANT, BLOCKED.
  - IDLE: mem_full → BLOCKED; else any eligible → GRANT; else stay in IDLE.
  - GRANT: mem_full → BLOCKED; else any eligible → GRANT (back-to-back); else IDLE.
  - BLOCKED: mem_full → stay in BLOCKED; else any eligible → GRANT; else IDLE.
  - A grant is issued exactly on transitions into GRANT, including GRANT→GRANT.
- fifo_full <= mem_full every cycle, in every state.
- err_cnt increments on each cycle with mem_wr_err=1 and saturates at all-ones. It is never cleared except by reset.
- Simultaneous mem_full and requests: mem_full wins. No grant is made and every req stays pending.
- A producer must not drop req before gnt. If it does, the request is simply withdrawn; there is no error.

## Timing
- Latency: req sampled at edge N gives gnt and mem_wr_en high during cycle N+1. One write per cycle maximum.
- Full contract: mem_full high at edge N means no mem_wr_en during cycle N+1. The memory asserts mem_full one slot early.
- gnt and mem_wr_en are asserted in the same cycle and are always coincident: |gnt equals mem_wr_en.
- The same requester can be granted at most every other cycle. Different requesters can be granted in consecutive cycles.
- Reset mid-operation: all outputs clear immediately and asynchronously. Any in-flight grant is lost. Producers re-request after reset.

## Structure
- Shared package fifo_param_pkg holds:
  - DATA_WIDTH.
  - The state enum arb_state_t {IDLE, GRANT, BLOCKED}.
  - The word typedef.
- One sub-module, rr_pick:
  - Purely combinational.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: one-hot winner, winner index, and a valid flag.
- The top level holds the FSM, registers and error counter.

## Test plan
- Reset: assert nRST=0 mid-grant → all outputs 0 at once. Release; with req=0 the block stays in IDLE and busy=0.
- Round-robin: req=4'b1111 held, each requester dropping req the cycle after its gnt → grants in order 0,1,2,3, one per cycle. mem_wdata equals each slice, for example 0xA0..0xA3.
- Fairness and masking:
  - req=4'b0101 held continuously → grants alternate 0,2,0,2.
  - No requester is granted in two consecutive cycles.
  - req=4'b0001 alone → gnt every other cycle.
- Full stall:
  - Raise mem_full while req=4'b0010 → no gnt or mem_wr_en; state is BLOCKED; fifo_full=1 one cycle later.
  - Drop mem_full → gnt[1] and mem_wr_en are asserted the next cycle.
- Wrap: rr_ptr=3 and req=4'b1001 → requester 3 is granted, then requester 0, then rr_ptr=1.
- Error counter (ERR_CNT_W=2): 5 cycles of mem_wr_err=1 → err_cnt counts 1,2,3,3,3.
